// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel frame buffer: frame limits, pixel width
// and the state encoding of the capture/serve FSM.
package sobel_pkg;

    localparam int unsigned MAX_W = 320;
    localparam int unsigned MAX_H = 240;
    localparam int unsigned PIX_W = 8;

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

endpackage

// File: rtl/sobel_frame_buffer_if.sv
// Bundle of the frame buffer's data-plane signals: UART byte input, frame
// dimensions, sobel read request/response, status flags and debug taps.
//
// Handshake: rx_valid and reload are one-cycle strobes with no ready
// back-pressure. The buffer samples them on every rising clk edge. A byte
// that cannot be stored (outside LOAD, or coincident with reload) is
// dropped rather than stalled. Reads are unconditional: the (H_read, W_read)
// address presented before an edge is answered on data0 right after it.
interface sobel_frame_buffer_if #(
    parameter int ADDR_W = 17
);
    import sobel_pkg::*;

    logic [15:0]       W;
    logic [15:0]       H;
    logic              rx_valid;
    logic [PIX_W-1:0]  rx_data;
    logic              reload;
    logic [15:0]       W_read;
    logic [15:0]       H_read;
    logic [PIX_W-1:0]  data0;
    logic              start;
    logic              dim_err;
    logic              overrun;
    logic [1:0]        dbg_state;
    logic [ADDR_W-1:0] dbg_wr_addr;

    modport master (
        output W, H, rx_valid, rx_data, reload, W_read, H_read,
        input  data0, start, dim_err, overrun, dbg_state, dbg_wr_addr
    );

    modport slave (
        input  W, H, rx_valid, rx_data, reload, W_read, H_read,
        output data0, start, dim_err, overrun, dbg_state, dbg_wr_addr
    );

endinterface

// File: rtl/sobel_pixel_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old
// contents (read-first). Contents are never reset.
module sobel_pixel_ram #(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    import sobel_pkg::*;

    logic [PIX_W-1:0] mem [0:DEPTH-1];

    // Write then registered read; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sobel_frame_buffer.sv
// Captures one raster-order grayscale frame from the UART byte stream,
// then raises start and serves (H_read, W_read) pixel reads on data0.
// Reset is asynchronous and active-high on rstn.
module sobel_frame_buffer #(
    parameter int MAX_W  = 320,
    parameter int MAX_H  = 240,
    parameter int DEPTH  = MAX_W * MAX_H,
    parameter int ADDR_W = 17
) (
    input  logic clk,
    input  logic rstn,
    sobel_frame_buffer_if.slave bus
);
    import sobel_pkg::*;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [15:0]       w_l;
    logic [15:0]       h_l;
    logic [15:0]       wr_col;
    logic [15:0]       wr_row;
    logic [ADDR_W-1:0] wr_addr;
    logic              start_q;
    logic              dim_err_q;
    logic              overrun_q;
    logic              dims_bad;
    logic              wr_last;
    logic              accept;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic              rd_ok_q;
    logic [PIX_W-1:0]  ram_q;

    // Dimensions are judged on the live inputs during INIT, i.e. on the
    // same values that get latched into w_l/h_l on that edge.
    assign dims_bad = (bus.W == 16'd0) || (bus.H == 16'd0) ||
                      (bus.W > 16'(MAX_W)) || (bus.H > 16'(MAX_H));

    assign wr_last = (wr_col == w_l - 16'd1) && (wr_row == h_l - 16'd1);

    // reload beats a coincident byte, so the byte is never written.
    assign accept = (state == LOAD) && bus.rx_valid && !bus.reload;

    // Row-major address; the product is formed at 32 bits then truncated.
    assign rd_addr     = ADDR_W'(32'(bus.H_read) * 32'(w_l) + 32'(bus.W_read));
    assign rd_in_range = (bus.H_read < h_l) && (bus.W_read < w_l);

    // Next-state selection; reload overrides every state.
    always_comb begin
        state_n = state;
        if (bus.reload) begin
            state_n = INIT;
        end else begin
            case (state)
                INIT:    state_n = dims_bad ? ERROR : LOAD;
                LOAD:    if (accept && wr_last) state_n = SERVE;
                default: state_n = state;
            endcase
        end
    end

    // State register; start/dim_err are registered decodes of the next state.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= INIT;
            start_q   <= 1'b0;
            dim_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            start_q   <= (state_n == SERVE);
            dim_err_q <= (state_n == ERROR);
        end
    end

    // Frame dimensions are captured only while in INIT.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            w_l <= 16'd0;
            h_l <= 16'd0;
        end else if (state == INIT) begin
            w_l <= bus.W;
            h_l <= bus.H;
        end
    end

    // Raster write position; restarts at pixel 0 on every INIT or reload.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_col  <= 16'd0;
            wr_row  <= 16'd0;
            wr_addr <= '0;
        end else if (bus.reload || (state == INIT)) begin
            wr_col  <= 16'd0;
            wr_row  <= 16'd0;
            wr_addr <= '0;
        end else if (accept) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_col == w_l - 16'd1) begin
                wr_col <= 16'd0;
                wr_row <= wr_row + 16'd1;
            end else begin
                wr_col <= wr_col + 16'd1;
            end
        end
    end

    // Sticky flag for bytes arriving after the frame is complete.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            overrun_q <= 1'b0;
        end else if (bus.reload || (state == INIT)) begin
            overrun_q <= 1'b0;
        end else if ((state == SERVE) && bus.rx_valid) begin
            overrun_q <= 1'b1;
        end
    end

    // Tracks whether the read launched last cycle was inside the frame.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_in_range;
        end
    end

    sobel_pixel_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (bus.rx_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // Out-of-frame reads (window overhang) and the reset state read as 0.
    assign bus.data0       = rd_ok_q ? ram_q : '0;
    assign bus.start       = start_q;
    assign bus.dim_err     = dim_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.dbg_state   = state;
    assign bus.dbg_wr_addr = wr_addr;

endmodule
